modular_inverter: RTL and testbench

//  Computes M = A^-1 mod p using the binary extended Euclidean algorithm, one step per clock.

---
 rtl/modular_inverter.sv | 132 +++++++++++++
 tb/tb_modular_inverter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/modular_inverter.sv
// Modular inverse M = A^-1 mod p by the binary extended Euclidean algorithm,
// one reduction step per clock, with a start/flag/busy handshake.
module modular_inverter #(
    parameter int n = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] p,
    output logic [n-1:0] M,
    output logic         flag,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [n-1:0] one_val   = n'(1);
    localparam logic [n-1:0] three_val = n'(3);

    state_t       state, state_nxt;
    logic [n-1:0] u, v, pm, u_nxt, v_nxt, pm_nxt, m_nxt;
    logic [n:0]   x1, x2, x1_nxt, x2_nxt, p_ext;
    logic         bad, bad_nxt, flag_nxt, busy_nxt, err_nxt;
    logic         accept, operand_bad, finish;

    assign p_ext       = {1'b0, pm};
    assign accept      = start && !busy && (state != RUN);
    assign operand_bad = !p[0] || (p < three_val) || (A == '0) || (A >= p);
    assign finish      = bad || (u == one_val) || (v == one_val) || (u == '0) || (v == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept) state_nxt = RUN;
            RUN:        if (finish) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Invariant while running: x1*A == u and x2*A == v (mod p), with x1, x2 in [0, p-1].
    always_comb begin
        u_nxt    = u;
        v_nxt    = v;
        pm_nxt   = pm;
        x1_nxt   = x1;
        x2_nxt   = x2;
        m_nxt    = M;
        bad_nxt  = bad;
        flag_nxt = flag;
        busy_nxt = busy;
        err_nxt  = err;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    u_nxt    = A;
                    v_nxt    = p;
                    pm_nxt   = p;
                    x1_nxt   = (n+1)'(1);
                    x2_nxt   = '0;
                    m_nxt    = '0;
                    bad_nxt  = operand_bad;
                    flag_nxt = 1'b0;
                    busy_nxt = 1'b1;
                    err_nxt  = 1'b0;
                end else if (busy) begin
                    flag_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            RUN: begin
                if (bad) begin
                    err_nxt = 1'b1;
                    m_nxt   = '0;
                end else if (u == one_val) begin
                    m_nxt = x1[n-1:0];
                end else if (v == one_val) begin
                    m_nxt = x2[n-1:0];
                end else if ((u == '0) || (v == '0)) begin
                    err_nxt = 1'b1;
                    m_nxt   = '0;
                end else if (!u[0]) begin
                    u_nxt  = u >> 1;
                    x1_nxt = x1[0] ? ((x1 + p_ext) >> 1) : (x1 >> 1);
                end else if (!v[0]) begin
                    v_nxt  = v >> 1;
                    x2_nxt = x2[0] ? ((x2 + p_ext) >> 1) : (x2 >> 1);
                end else if (u >= v) begin
                    u_nxt  = u - v;
                    x1_nxt = (x1 >= x2) ? (x1 - x2) : (x1 + p_ext - x2);
                end else begin
                    v_nxt  = v - u;
                    x2_nxt = (x2 >= x1) ? (x2 - x1) : (x2 + p_ext - x1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u    <= '0;
            v    <= '0;
            pm   <= '0;
            x1   <= '0;
            x2   <= '0;
            M    <= '0;
            bad  <= 1'b0;
            flag <= 1'b0;
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            u    <= u_nxt;
            v    <= v_nxt;
            pm   <= pm_nxt;
            x1   <= x1_nxt;
            x2   <= x2_nxt;
            M    <= m_nxt;
            bad  <= bad_nxt;
            flag <= flag_nxt;
            busy <= busy_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_modular_inverter.sv
// Scoreboard bench for modular_inverter: a driver pushes reference results,
// a monitor pops and compares them whenever the done flag rises.
module tb_modular_inverter;

    localparam int N = 10;
    localparam int MAX_LAT = 4 * N + 3;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] A, p, M;
    logic         flag, busy, err;

    typedef struct {
        int   a;
        int   pm;
        logic e;
        int   m;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic flag_q = 1'b0;
    exp_t cur;
    int   lat;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    modular_inverter #(.n(N)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .p(p),
        .M(M), .flag(flag), .busy(busy), .err(err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: exhaustive search for the multiplicative inverse.
    function automatic void refModel(input int a, input int pm, output logic e, output int m);
        e = 1'b1;
        m = 0;
        if ((pm % 2 == 0) || (pm < 3) || (a == 0) || (a >= pm)) return;
        for (int k = 1; k < pm; k++) begin
            if ((a * k) % pm == 1) begin
                e = 1'b0;
                m = k;
                return;
            end
        end
    endfunction

    task automatic applyStimulus(input int a, input int pm);
        int   waited = 0;
        logic e;
        int   m;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            checkOutput("busy_timeout", 1, 0);
            return;
        end
        A = N'(a);
        p = N'(pm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = N'($urandom);
        p = N'($urandom);
        refModel(a, pm, e, m);
        sb.push_back('{a: a, pm: pm, e: e, m: m, acc: cyc});
    endtask

    task automatic drainQueue();
        int waited = 0;
        while (sb.size() > 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset && flag && !flag_q) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_flag", 1, 0);
            end else begin
                cur = sb.pop_front();
                lat = cyc - cur.acc;
                checkOutput($sformatf("err(A=%0d,p=%0d)", cur.a, cur.pm), int'(err), int'(cur.e));
                checkOutput($sformatf("M(A=%0d,p=%0d)", cur.a, cur.pm), int'(M), cur.m);
                if (cur.a == 1 && !cur.e)
                    checkOutput("latency_a1", lat, 2);
                else
                    checkOutput($sformatf("latency_ok(%0d)", lat), int'(lat <= MAX_LAT), 1);
            end
        end
        flag_q = flag;
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        A = '0;
        p = '0;
        #12;
        checkOutput("reset_M", int'(M), 0);
        checkOutput("reset_flag", int'(flag), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(3, 1009);
        applyStimulus(1, 1009);
        applyStimulus(1008, 1009);
        applyStimulus(0, 1009);
        applyStimulus(2, 15);
        applyStimulus(6, 15);
        applyStimulus(3, 8);
        applyStimulus(5, 1);
        drainQueue();

        // A second start while busy must not disturb the operation in flight.
        applyStimulus(3, 1009);
        repeat (3) @(negedge clk);
        A = N'(5);
        p = N'(1009);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drainQueue();

        // Asynchronous abort mid-operation, then a clean restart.
        applyStimulus(3, 1009);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_M", int'(M), 0);
        checkOutput("abort_flag", int'(flag), 0);
        checkOutput("abort_busy", int'(busy), 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(2, 15);
        drainQueue();

        for (int i = 0; i < 500; i++) applyStimulus(int'($urandom_range(1, 1008)), 1009);
        for (int i = 0; i < 60; i++) begin
            int pm;
            pm = int'($urandom_range(1, 511)) * 2 + 1;
            applyStimulus(int'($urandom_range(0, pm)), pm);
        end
        drainQueue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
